fpmul_param: RTL and testbench

FPMUL_PARAM -- requirements
Module: fpmul_param

---
 rtl/fpmul_param_if.sv | 30 +++
 rtl/fpmul_param.sv | 237 +++++++++++++++++++++++
 tb/tb_fpmul_param.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpmul_param_if.sv
// Handshake and operand/result bundle for the iterative FP multiplier.
interface fpmul_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] P;
    logic         OF;
    logic         UF;
    logic         NaNF;
    logic         InfF;
    logic         DNF;
    logic         ZF;

    modport master (
        output Start, A, B,
        input  Busy, Done, P, OF, UF, NaNF, InfF, DNF, ZF
    );

    modport slave (
        input  Start, A, B,
        output Busy, Done, P, OF, UF, NaNF, InfF, DNF, ZF
    );
endinterface

// File: rtl/fpmul_param.sv
// Iterative shift-add floating-point multiplier, denormals flushed to zero.
// Define FPMUL_PARAM_RNE_EN for round-to-nearest-even, else truncation.
module fpmul_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic          Clk,
    input logic          Rst_n,
    fpmul_param_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 1;
    localparam int PW = 2 * N;
    localparam int XW = EXP_W + 2;
    localparam int CW = $clog2(N + 1);

    localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EZERO = '0;
    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, CHECK, MUL, NORM, ROUND, PACK
    } state_t;

    typedef enum logic [1:0] {
        K_NUM, K_NAN, K_INF, K_ZERO
    } kind_t;

    state_t state, nxt;
    kind_t  kind_r, kind_c;

    logic [W-1:0]         a_r, b_r;
    logic [N-1:0]         mcand;
    logic [PW-1:0]        prod;
    logic [CW-1:0]        cnt;
    logic signed [XW-1:0] exp_r;
    logic [MAN_W-1:0]     mant_r;
    logic                 sign_r;
    logic                 dn_r;

    logic [W-1:0] p_r;
    logic of_r, uf_r, nan_r, inf_r, dnf_r, zf_r, done_r;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic nan_a, nan_b, inf_a, inf_b, dn_a, dn_b, zero_a, zero_b;
    logic signed [XW-1:0] exp_sum;
    logic [N:0]           sum_c;
    logic [MAN_W-1:0]     mant_c;
    logic [MAN_W:0]       rnd;
    logic is_nan, is_inf, is_zero, is_ovf, is_unf, is_fin;

    assign ea = a_r[W-2:MAN_W];
    assign eb = b_r[W-2:MAN_W];
    assign fa = a_r[MAN_W-1:0];
    assign fb = b_r[MAN_W-1:0];

    assign nan_a  = (&ea) & (|fa);
    assign nan_b  = (&eb) & (|fb);
    assign inf_a  = (&ea) & ~(|fa);
    assign inf_b  = (&eb) & ~(|fb);
    assign dn_a   = ~(|ea) & (|fa);
    assign dn_b   = ~(|eb) & (|fb);
    assign zero_a = ~(|ea);
    assign zero_b = ~(|eb);

    always_comb begin
        kind_c = K_NUM;
        if (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a))
            kind_c = K_NAN;
        else if (inf_a | inf_b)
            kind_c = K_INF;
        else if (zero_a | zero_b)
            kind_c = K_ZERO;
    end

    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    // Add the multiplicand into the upper half when the multiplier LSB is set.
    assign sum_c = {1'b0, prod[PW-1:N]} + {1'b0, (prod[0] ? mcand : {N{1'b0}})};

    assign mant_c = prod[PW-3:N-1];

`ifdef FPMUL_PARAM_RNE_EN
    logic lost_r;
    logic g, s, inc;
    assign g   = prod[N-2];
    assign s   = (|prod[N-3:0]) | lost_r;
    assign inc = g & (s | mant_c[0]);
    assign rnd = {1'b0, mant_c} + {{MAN_W{1'b0}}, inc};
`else
    assign rnd = {1'b0, mant_c};
`endif

    assign is_nan  = (kind_r == K_NAN);
    assign is_inf  = (kind_r == K_INF);
    assign is_zero = (kind_r == K_ZERO);
    assign is_ovf  = (kind_r == K_NUM) & (exp_r >= EMAX);
    assign is_unf  = (kind_r == K_NUM) & (exp_r <= EZERO);
    assign is_fin  = (kind_r == K_NUM) & ~(exp_r >= EMAX) & ~(exp_r <= EZERO);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.Start) nxt = CHECK;
            CHECK:   nxt = (kind_c == K_NUM) ? MUL : PACK;
            MUL:     if (cnt == CW'(N - 1)) nxt = NORM;
            NORM:    nxt = ROUND;
            ROUND:   nxt = PACK;
            PACK:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
            exp_r  <= '0;
            mant_r <= '0;
            sign_r <= 1'b0;
            dn_r   <= 1'b0;
            kind_r <= K_NUM;
`ifdef FPMUL_PARAM_RNE_EN
            lost_r <= 1'b0;
`endif
            p_r    <= '0;
            of_r   <= 1'b0;
            uf_r   <= 1'b0;
            nan_r  <= 1'b0;
            inf_r  <= 1'b0;
            dnf_r  <= 1'b0;
            zf_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state == PACK);
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        a_r <= bus.A;
                        b_r <= bus.B;
                    end
                end
                CHECK: begin
                    sign_r <= a_r[W-1] ^ b_r[W-1];
                    kind_r <= kind_c;
                    dn_r   <= dn_a | dn_b;
                    exp_r  <= exp_sum;
                    mcand  <= {1'b1, fb};
                    prod   <= {{N{1'b0}}, 1'b1, fa};
                    cnt    <= '0;
`ifdef FPMUL_PARAM_RNE_EN
                    lost_r <= 1'b0;
`endif
                end
                MUL: begin
                    prod <= {sum_c, prod[N-1:1]};
                    cnt  <= cnt + 1'b1;
                end
                NORM: begin
                    if (prod[PW-1]) begin
                        prod  <= prod >> 1;
                        exp_r <= exp_r + XW'(1);
`ifdef FPMUL_PARAM_RNE_EN
                        lost_r <= prod[0];
`endif
                    end
                end
                ROUND: begin
                    // A carry out leaves 1.000..; the hidden bit absorbs it.
                    mant_r <= rnd[MAN_W-1:0];
                    if (rnd[MAN_W])
                        exp_r <= exp_r + XW'(1);
                end
                PACK: begin
                    of_r  <= 1'b0;
                    uf_r  <= 1'b0;
                    nan_r <= 1'b0;
                    inf_r <= 1'b0;
                    zf_r  <= 1'b0;
                    dnf_r <= dn_r;
                    unique case (1'b1)
                        is_nan: begin
                            p_r   <= QNAN;
                            nan_r <= 1'b1;
                        end
                        is_inf: begin
                            p_r   <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            inf_r <= 1'b1;
                        end
                        is_zero: begin
                            p_r  <= {sign_r, {(W-1){1'b0}}};
                            zf_r <= 1'b1;
                        end
                        is_ovf: begin
                            p_r   <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            of_r  <= 1'b1;
                            inf_r <= 1'b1;
                        end
                        is_unf: begin
                            p_r  <= {sign_r, {(W-1){1'b0}}};
                            uf_r <= 1'b1;
                            zf_r <= 1'b1;
                        end
                        is_fin: begin
                            p_r <= {sign_r, exp_r[EXP_W-1:0], mant_r};
                        end
                        default: p_r <= p_r;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = done_r;
    assign bus.P    = p_r;
    assign bus.OF   = of_r;
    assign bus.UF   = uf_r;
    assign bus.NaNF = nan_r;
    assign bus.InfF = inf_r;
    assign bus.DNF  = dnf_r;
    assign bus.ZF   = zf_r;
endmodule

// File: tb/tb_fpmul_param.sv
// Bench for fpmul_param: directed vectors plus random operands against an
// integer-arithmetic reference model. Flag vector order: {OF,UF,NaNF,InfF,DNF,ZF}.
module tb_fpmul_param;
    localparam int EW = 8;
    localparam int MW = 23;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fpmul_param_if #(.EXP_W(EW), .MAN_W(MW)) bus ();

    fpmul_param #(.EXP_W(EW), .MAN_W(MW)) dut (
        .Clk  (clk),
        .Rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {bus.OF, bus.UF, bus.NaNF, bus.InfF, bus.DNF, bus.ZF};
    endfunction

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] p, output logic [5:0] f,
                                  output bit sp);
        int ea, eb, e, sh;
        longint unsigned fa, fb, m, mant;
        bit s, nan_a, nan_b, inf_a, inf_b, dn_a, dn_b, z_a, z_b;
`ifdef FPMUL_PARAM_RNE_EN
        longint unsigned rem, half;
`endif
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = 64'(a[22:0]);
        fb = 64'(b[22:0]);
        s = a[31] ^ b[31];
        nan_a = (ea == 255) && (fa != 0);
        nan_b = (eb == 255) && (fb != 0);
        inf_a = (ea == 255) && (fa == 0);
        inf_b = (eb == 255) && (fb == 0);
        dn_a = (ea == 0) && (fa != 0);
        dn_b = (eb == 0) && (fb != 0);
        z_a = (ea == 0);
        z_b = (eb == 0);
        f = 6'b0;
        sp = 1'b1;
        if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a)) begin
            p = 32'h7FC00000;
            f = 6'b001000;
        end else if (inf_a || inf_b) begin
            p = {s, 8'hFF, 23'd0};
            f = 6'b000100;
        end else if (z_a || z_b) begin
            p = {s, 31'd0};
            f = 6'b000001;
        end else begin
            sp = 1'b0;
            m = (fa | (64'd1 << 23)) * (fb | (64'd1 << 23));
            e = ea + eb - 127;
            sh = 23;
            if ((m >> 47) != 0) begin
                sh = 24;
                e++;
            end
            mant = m >> sh;
`ifdef FPMUL_PARAM_RNE_EN
            rem  = m & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0]))
                mant++;
`endif
            if (mant == (64'd1 << 24)) begin
                mant = mant >> 1;
                e++;
            end
            if (e >= 255) begin
                p = {s, 8'hFF, 23'd0};
                f = 6'b100100;
            end else if (e <= 0) begin
                p = {s, 31'd0};
                f = 6'b010001;
            end else begin
                p = {s, e[7:0], mant[22:0]};
            end
        end
        f[1] = dn_a | dn_b;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input bit rel, output int lat, output int busy_n);
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        lat = 0;
        busy_n = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.Done) break;
            if (bus.Busy) busy_n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ep,
                         input logic [5:0] ef, input int elat, input bit rel);
        int lat, busy_n;
        logic [31:0] p;
        run_op(a, b, rel, lat, busy_n);
        p = bus.P;
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_P"}, 64'(bus.P), 64'(ep));
        check({tag, "_flags"}, 64'(flags()), 64'(ef));
        check({tag, "_busy_cyc"}, 64'(busy_n), 64'(elat - 1));
        check({tag, "_busy_done"}, 64'(bus.Busy), 64'(0));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(bus.Done), 64'(0));
        check({tag, "_P_hold"}, 64'(bus.P), 64'(p));
    endtask

    initial begin
        logic [31:0] a, b, ep;
        logic [5:0]  ef;
        bit sp;
        int lat, busy_n, dn_seen;

        bus.Start = 1'b0;
        bus.A = '0;
        bus.B = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_P", 64'(bus.P), 64'(0));
        check("rst_flags", 64'(flags()), 64'(0));
        check("rst_busy_done", 64'({bus.Busy, bus.Done}), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 6'b000000, 28, 1'b0);
        do_op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 6'b001000, 2, 1'b0);
        do_op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 6'b100100, 28, 1'b0);
        do_op("underflow", 32'h0DA24260, 32'h0DA24260, 32'h00000000, 6'b010001, 28, 1'b0);
`ifdef FPMUL_PARAM_RNE_EN
        do_op("tie", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 6'b000000, 28, 1'b0);
`else
        do_op("tie", 32'h3F800001, 32'h3FC00000, 32'h3FC00001, 6'b000000, 28, 1'b0);
`endif
        do_op("denorm", 32'h00000001, 32'h3F800000, 32'h00000000, 6'b000011, 2, 1'b0);
        do_op("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 6'b001000, 2, 1'b0);
        do_op("inf_x_neg", 32'h7F800000, 32'hC0000000, 32'hFF800000, 6'b000100, 2, 1'b0);
        do_op("negzero", 32'h80000000, 32'h3F800000, 32'h80000000, 6'b000001, 2, 1'b0);

        // Start re-pulse in the middle of an operation must be ignored.
        @(negedge clk);
        bus.A = 32'h3FC00000;
        bus.B = 32'h40000000;
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.A = 32'h40800000;
        bus.B = 32'h40800000;
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        lat = 5;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.Done) break;
        end
        check("restart_lat", 64'(lat), 64'(28));
        check("restart_P", 64'(bus.P), 64'h40400000);
        check("restart_flags", 64'(flags()), 64'(0));

        // Reset in the middle of the next operation aborts it.
        @(negedge clk);
        bus.A = 32'h40000000;
        bus.B = 32'h40400000;
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_P", 64'(bus.P), 64'(0));
        check("abort_flags", 64'(flags()), 64'(0));
        check("abort_busy_done", 64'({bus.Busy, bus.Done}), 64'(0));
        dn_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.Done) dn_seen++;
        end
        check("abort_no_done", 64'(dn_seen), 64'(0));
        do_op("after_rst", 32'h40000000, 32'h40400000, 32'h40C00000, 6'b000000, 28, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                a = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
                b = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            end else if (i % 4 == 1) begin
                a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
                b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            end else begin
                a = $urandom;
                b = $urandom;
            end
            model(a, b, ep, ef, sp);
            run_op(a, b, 1'b0, lat, busy_n);
            check($sformatf("rnd%0d_P a=%h b=%h", i, a, b), 64'(bus.P), 64'(ep));
            check($sformatf("rnd%0d_flags", i), 64'(flags()), 64'(ef));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(sp ? 2 : 28));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
